gray_tracker: RTL
=================

# gray_tracker

Downstream monitor for the Gray-code counter stage. It samples the counter's Gray output and sticky overflow flag, decodes Gray to binary, and checks that every change is a legal single forward step. It counts completed wraps and latches a sticky fault on any illegal transition. It provides the datapath and debug logic with a binary count, a step strobe and a health flag.

## Interface
- WIDTH, 3: Gray code width; matches the upstream counter.
- WRAP_W, 8: width of the wrap counter.
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Clear  in  1  synchronous soft clear; returns the block to SYNC.
- Valid  in  1  Gray/Overflow_in are sampled this cycle.
- Gray  in  WIDTH  Gray code from the upstream counter.
- Overflow_in  in  1  sticky overflow flag from the upstream counter.
- Bin  out  WIDTH  binary equivalent of the last accepted Gray value.
- Step  out  1  one-cycle pulse per accepted forward step.
- Wraps  out  WRAP_W  count of max→0 wraps; saturating.
- Wrap_sat  out  1  Wraps has reached all-ones.
- Error  out  1  sticky illegal-transition flag.

## Operation
- States: SYNC (no reference value yet), TRACK, FAULT. Reset and Clear both enter SYNC.
- SYNC, Valid=1:
  - Latch Gray as prev.
  - Bin ← g2b(Gray).
  - Go to TRACK.
  - No legality check and no Step.
- TRACK, Valid=1, let b = g2b(Gray), p = g2b(prev):
  - Gray == prev: hold; no Step.
  - b == p+1 mod 2^WIDTH: Bin ← b, prev ← Gray, Step=1.
  - If additionally p == 2^WIDTH−1 (wrap): Wraps increments, saturating at all-ones. Wrap_sat=1 when Wraps is all-ones.
  - Any other change (multi-bit change, backward step, skip): Error ← 1, go to FAULT. Bin, prev and Wraps are unchanged.
- FAULT: all outputs hold and Valid is ignored. Exits only via Reset or Clear.
- Valid=0: no state change in any state.
- Clear and Valid in the same cycle: Clear wins; the sample is discarded.
- Reset overrides Clear.
- Arithmetic: increment compare is modulo 2^WIDTH. Wraps never rolls over.

## Timing
- Reset (Reset=0 at an edge):
  - Bin=0, Step=0, Wraps=0, Wrap_sat=0, Error=0.
  - State SYNC, prev=0.
- All outputs are registered.
- Latency: Valid sampled at edge N produces Bin, Step, Wraps and Error at edge N (visible during cycle N+1).
- Step is high for exactly one cycle per accepted step and is 0 in every cycle without an accepted step.
- Error rises in the same cycle as the FAULT entry.
- Clear takes effect at the edge where it is sampled. All outputs then equal their reset values.
- Back-to-back Valid every cycle is supported; there is no throughput limit.

## Configuration
- OVF_CHECK_EN defined:
  - Overflow_in is checked against wrap history on each Valid sample in TRACK.
  - Overflow_in=1 while Wraps==0 and the current sample is not a wrap → Error, FAULT.
  - Overflow_in=0 while Wraps≠0 → Error, FAULT.
- OVF_CHECK_EN undefined: Overflow_in is ignored, with no logic generated for it.

## Structure
- Shared package gray_pkg holds:
  - state encoding localparams (SYNC, TRACK, FAULT);
  - default WIDTH and WRAP_W constants.
- Sub-module gray2bin: parameterised combinational Gray→binary decoder (XOR prefix). Instantiated twice: current sample and prev.

## Test plan
- WIDTH=3, reset, then Valid with Gray 000,001,011,010,110,111,101,100,000 → Bin 0,1,2,…,7,0; 8 Step pulses; Wraps=1; Error=0.
- TRACK at Gray 001, then Valid with Gray 010 (two-bit change) → Error=1, FAULT; Bin stays 1; later Valid samples are ignored.
- Gray 011 held with Valid for 5 cycles → Bin=2, no Step; then 011→001 (backward) → Error=1.
- WRAP_W=2, 4 full sequences → Wraps=3, Wrap_sat=1 after the 3rd wrap and holding; Error=0.
- Clear asserted together with Valid(Gray 110) in TRACK or FAULT → all outputs 0, state SYNC. Next Valid(Gray 101) → Bin=6, no Error, no Step.
- OVF_CHECK_EN: Overflow_in=1 with Wraps=0 on a non-wrap sample → Error=1. Without the macro, the same stimulus → Error=0.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code tracker: state encoding and default sizes.
package gray_pkg;

  // Tracker state encoding.
  typedef logic [1:0] state_t;

  localparam state_t SYNC  = 2'd0;  // no reference value captured yet
  localparam state_t TRACK = 2'd1;  // following the upstream counter
  localparam state_t FAULT = 2'd2;  // illegal transition seen; frozen

  // Default sizes matching the upstream Gray counter.
  localparam int DEF_WIDTH  = 3;
  localparam int DEF_WRAP_W = 8;

endpackage : gray_pkg

// File: rtl/gray_tracker_gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all
// Gray bits at and above its position.
module gray2bin #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] Gray,
  output logic [WIDTH-1:0] Bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign Bin[i] = ^(Gray >> i);
  end

endmodule : gray2bin

// File: rtl/gray_tracker.sv
// Gray-code counter monitor: decodes the upstream Gray value, checks that every
// change is a single forward step, counts wraps and latches a sticky fault.
// Optional build macro: OVF_CHECK_EN -- cross-checks Overflow_in against the
// wrap history; when undefined Overflow_in is ignored.
module gray_tracker
  import gray_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WRAP_W = DEF_WRAP_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              Valid,
  input  logic [WIDTH-1:0]  Gray,
  input  logic              Overflow_in,
  output logic [WIDTH-1:0]  Bin,
  output logic              Step,
  output logic [WRAP_W-1:0] Wraps,
  output logic              Wrap_sat,
  output logic              Error
);

  localparam logic [WIDTH-1:0]  BIN_MAX   = {WIDTH{1'b1}};
  localparam logic [WRAP_W-1:0] WRAPS_MAX = {WRAP_W{1'b1}};
  localparam logic [WRAP_W-1:0] WRAPS_MIN = {WRAP_W{1'b0}};

  state_t            state_r, state_nxt_s;
  logic [WIDTH-1:0]  prev_r, prev_nxt_s;
  logic [WIDTH-1:0]  bin_r, bin_nxt_s;
  logic              step_r, step_nxt_s;
  logic [WRAP_W-1:0] wraps_r, wraps_nxt_s;
  logic              wrap_sat_r;
  logic              error_r, error_nxt_s;

  logic [WIDTH-1:0]  cur_bin_s, prev_bin_s, inc_bin_s;
  logic              is_same_s, is_step_s, is_wrap_s, ovf_err_s, illegal_s;

  gray2bin #(.WIDTH(WIDTH)) u_cur_dec  (.Gray(Gray),   .Bin(cur_bin_s));
  gray2bin #(.WIDTH(WIDTH)) u_prev_dec (.Gray(prev_r), .Bin(prev_bin_s));

  // Increment compare wraps naturally modulo 2^WIDTH through truncation.
  assign inc_bin_s = prev_bin_s + WIDTH'(1'b1);
  assign is_same_s = (Gray == prev_r);
  assign is_step_s = (cur_bin_s == inc_bin_s);
  assign is_wrap_s = is_step_s && (prev_bin_s == BIN_MAX);

`ifdef OVF_CHECK_EN
  // Overflow must be clear before the first wrap (unless this sample wraps)
  // and must stay set once any wrap has been counted.
  assign ovf_err_s = (Overflow_in && (wraps_r == WRAPS_MIN) && !is_wrap_s) ||
                     (!Overflow_in && (wraps_r != WRAPS_MIN));
`else
  logic ovf_unused_s;
  assign ovf_unused_s = Overflow_in;
  assign ovf_err_s    = 1'b0;
`endif

  assign illegal_s = ovf_err_s || (!is_same_s && !is_step_s);

  // State and output registers; Reset and Clear both return to SYNC.
  always_ff @(posedge Clk) begin
    if (!Reset || Clear) begin
      state_r    <= SYNC;
      prev_r     <= {WIDTH{1'b0}};
      bin_r      <= {WIDTH{1'b0}};
      step_r     <= 1'b0;
      wraps_r    <= WRAPS_MIN;
      wrap_sat_r <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      prev_r     <= prev_nxt_s;
      bin_r      <= bin_nxt_s;
      step_r     <= step_nxt_s;
      wraps_r    <= wraps_nxt_s;
      wrap_sat_r <= (wraps_nxt_s == WRAPS_MAX);
      error_r    <= error_nxt_s;
    end
  end

  // Next-state selection; FAULT is left only through Reset or Clear.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SYNC: begin
        if (Valid) state_nxt_s = TRACK;
        else       state_nxt_s = SYNC;
      end
      TRACK: begin
        if (Valid && illegal_s) state_nxt_s = FAULT;
        else                    state_nxt_s = TRACK;
      end
      FAULT:   state_nxt_s = FAULT;
      default: state_nxt_s = SYNC;
    endcase
  end

  // Next values of the registered outputs and the reference Gray value.
  always_comb begin
    prev_nxt_s  = prev_r;
    bin_nxt_s   = bin_r;
    step_nxt_s  = 1'b0;
    wraps_nxt_s = wraps_r;
    error_nxt_s = error_r;
    case (state_r)
      SYNC: begin
        if (Valid) begin
          prev_nxt_s = Gray;
          bin_nxt_s  = cur_bin_s;
        end else begin
          prev_nxt_s = prev_r;
        end
      end
      TRACK: begin
        if (Valid && illegal_s) begin
          error_nxt_s = 1'b1;
        end else if (Valid && is_step_s) begin
          prev_nxt_s = Gray;
          bin_nxt_s  = cur_bin_s;
          step_nxt_s = 1'b1;
          if (is_wrap_s && (wraps_r != WRAPS_MAX)) wraps_nxt_s = wraps_r + WRAP_W'(1'b1);
          else                                      wraps_nxt_s = wraps_r;
        end else begin
          prev_nxt_s = prev_r;
        end
      end
      FAULT:   error_nxt_s = error_r;
      default: error_nxt_s = error_r;
    endcase
  end

  assign Bin      = bin_r;
  assign Step     = step_r;
  assign Wraps    = wraps_r;
  assign Wrap_sat = wrap_sat_r;
  assign Error    = error_r;

endmodule : gray_tracker
